retire_release: RTL and testbench

Commit-side counterpart of register renaming. Accepts up to MACHINE_WIDTH retiring instructions per cycle from the ROB head and updates the architectural (committed) RAT. Returns each retiring instruction's superseded physical register to the free list release ports. On a pipeline flush, a multi-cycle recovery walk replays the committed mapping into the speculative RAT.

---
 rtl/retire_release.sv | 126 ++++++++++++
 tb/tb_retire_release.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/retire_release.sv
// Commit-side rename bookkeeping: maintains the architectural RAT, emits one-cycle-late
// free-list releases for superseded pregs, and walks the committed map back on flush.
module retire_release #(
  parameter int MACHINE_WIDTH = 2,
  parameter int AREG_NUM      = 32,
  parameter int PREG_NUM      = 64,
  parameter int AREG_W        = $clog2(AREG_NUM),
  parameter int PREG_W        = $clog2(PREG_NUM)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MACHINE_WIDTH-1:0]              commit_valid,
  input  logic [MACHINE_WIDTH-1:0][AREG_W-1:0]  commit_dst,
  input  logic [MACHINE_WIDTH-1:0][PREG_W-1:0]  commit_pdst,
  input  logic [MACHINE_WIDTH-1:0][PREG_W-1:0]  commit_old_pdst,
  output logic                                  commit_ready,
  input  logic                                  flush,
  output logic [MACHINE_WIDTH-1:0]              rel_valid,
  output logic [MACHINE_WIDTH-1:0][PREG_W-1:0]  rel_id,
  output logic [MACHINE_WIDTH-1:0]              rec_valid,
  output logic [MACHINE_WIDTH-1:0][AREG_W-1:0]  rec_areg,
  output logic [MACHINE_WIDTH-1:0][PREG_W-1:0]  rec_preg,
  output logic                                  rec_busy,
  output logic                                  rec_done,
  output logic [1:0]                            dbg_state
);

  localparam int WALK_LEN = AREG_NUM / MACHINE_WIDTH;
  localparam int CNT_W    = (WALK_LEN > 1) ? $clog2(WALK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WALK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECOVER = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [PREG_W-1:0]               arat [AREG_NUM];
  logic [MACHINE_WIDTH-1:0]        commit_wr;

  // Handshake: slot i transfers when commit_valid[i] && commit_ready in the same cycle;
  // commit_ready depends only on state, so the ROB may hold valid high across stalls.
  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      commit_wr[i] = commit_valid[i] && commit_ready && (commit_dst[i] != '0);
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    commit_ready = 1'b0;
    rec_done     = 1'b0;
    case (state)
      S_IDLE: begin
        commit_ready = 1'b1;
        if (flush) begin
          state_nxt = S_RECOVER;
          cnt_nxt   = '0;
        end
      end
      S_RECOVER: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end
      end
      S_DONE: begin
        rec_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rec_busy  = (state != S_IDLE);
  assign dbg_state = state;

  // Walk ports read only registered state, so no input reaches rec_* combinationally.
  always_comb begin
    logic [AREG_W-1:0] areg;
    for (int j = 0; j < MACHINE_WIDTH; j++) begin
      areg        = AREG_W'(int'(cnt) * MACHINE_WIDTH + j);
      rec_valid[j] = 1'b0;
      rec_areg[j]  = '0;
      rec_preg[j]  = '0;
      if (state == S_RECOVER) begin
        rec_valid[j] = (areg != '0);
        rec_areg[j]  = areg;
        rec_preg[j]  = arat[areg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rel_valid <= '0;
      rel_id    <= '0;
      for (int i = 0; i < AREG_NUM; i++) begin
        arat[i] <= PREG_W'(i % PREG_NUM);
      end
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rel_valid <= commit_wr;
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        rel_id[i] <= commit_wr[i] ? commit_old_pdst[i] : '0;
      end
      // Ascending slot order: the youngest same-cycle writer to a dst lands last.
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (commit_wr[i]) begin
          arat[commit_dst[i]] <= commit_pdst[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_retire_release.sv
// Bench for retire_release: table vectors plus hand sequences, checked against a small
// architectural-map model and a release scoreboard queue.
`timescale 1ns/1ps
module tb_retire_release;

  localparam int MW   = 2;
  localparam int AN   = 32;
  localparam int PN   = 64;
  localparam int AW   = 5;
  localparam int PW   = 6;
  localparam int WALK = AN / MW;
  localparam int SBW  = MW + MW * PW;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [MW-1:0]           commit_valid;
  logic [MW-1:0][AW-1:0]   commit_dst;
  logic [MW-1:0][PW-1:0]   commit_pdst;
  logic [MW-1:0][PW-1:0]   commit_old_pdst;
  logic                    commit_ready;
  logic                    flush;
  logic [MW-1:0]           rel_valid;
  logic [MW-1:0][PW-1:0]   rel_id;
  logic [MW-1:0]           rec_valid;
  logic [MW-1:0][AW-1:0]   rec_areg;
  logic [MW-1:0][PW-1:0]   rec_preg;
  logic                    rec_busy;
  logic                    rec_done;
  logic [1:0]              dbg_state;

  always #5 clk = ~clk;

  retire_release #(
    .MACHINE_WIDTH(MW), .AREG_NUM(AN), .PREG_NUM(PN)
  ) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_dst(commit_dst), .commit_pdst(commit_pdst),
    .commit_old_pdst(commit_old_pdst), .commit_ready(commit_ready), .flush(flush),
    .rel_valid(rel_valid), .rel_id(rel_id),
    .rec_valid(rec_valid), .rec_areg(rec_areg), .rec_preg(rec_preg),
    .rec_busy(rec_busy), .rec_done(rec_done), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [1:0]    v;
    logic [AW-1:0] d0, d1;
    logic [PW-1:0] p0, p1, o0, o1;
    logic [1:0]    exp_rv;
  } vec_t;

  vec_t           vecs [6];
  int             n_checks = 0;
  int             n_pass   = 0;
  int             blocked  = 0;
  logic [PW-1:0]  m_arat [AN];
  logic [SBW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive inputs, advance the model, then sample #1 after the edge.
  task automatic tick(input logic rst, input logic fl, input logic [1:0] v,
                      input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                      input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                      input logic [PW-1:0] o0, input logic [PW-1:0] o1,
                      input logic [1:0] exp_rv);
    logic [SBW-1:0]        e, a;
    logic [MW-1:0]         ev;
    logic [MW-1:0][AW-1:0] ea;
    logic [MW-1:0][PW-1:0] ep;
    logic                  ready_exp;
    int                    k, ar;
    reset           = rst;
    flush           = fl;
    commit_valid    = v;
    commit_dst      = {d1, d0};
    commit_pdst     = {p1, p0};
    commit_old_pdst = {o1, o0};
    exp_q.push_back({exp_rv, (exp_rv[1] ? o1 : PW'(0)), (exp_rv[0] ? o0 : PW'(0))});
    ready_exp = (blocked == 0);
    if (rst) begin
      blocked = 0;
      for (int i = 0; i < AN; i++) m_arat[i] = PW'(i);
    end else begin
      if (ready_exp && v[0] && d0 != 0) m_arat[d0] = p0;
      if (ready_exp && v[1] && d1 != 0) m_arat[d1] = p1;
      if (ready_exp && fl) blocked = WALK + 1;
      else if (blocked > 0) blocked--;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      a = {rel_valid, (e[SBW-1] ? rel_id[1] : PW'(0)), (e[SBW-2] ? rel_id[0] : PW'(0))};
      check("release", 64'(a), 64'(e));
    end
    check("commit_ready", 64'(commit_ready), 64'(blocked == 0));
    check("rec_busy", 64'(rec_busy), 64'(blocked != 0));
    check("rec_done", 64'(rec_done), 64'(blocked == 1));
    ev = '0; ea = '0; ep = '0;
    if (blocked >= 2) begin
      k = WALK + 2 - blocked;
      for (int j = 0; j < MW; j++) begin
        ar    = (k - 1) * MW + j;
        ev[j] = (ar != 0);
        ea[j] = AW'(ar);
        ep[j] = m_arat[ar];
      end
      check("rec_areg", 64'(rec_areg), 64'(ea));
      check("rec_preg", 64'(rec_preg), 64'(ep));
    end
    check("rec_valid", 64'(rec_valid), 64'(ev));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
  endtask

  task automatic do_flush();
    tick(1'b0, 1'b1, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    rv, rexp;
    logic [AW-1:0] rd0, rd1;
    logic [PW-1:0] rp0, rp1, ro0, ro1;
    vecs[0] = '{2'b01, 5'd5,  5'd9,  6'd40, 6'd41, 6'd5,  6'd9,  2'b01};
    vecs[1] = '{2'b11, 5'd7,  5'd7,  6'd33, 6'd34, 6'd7,  6'd33, 2'b11};
    vecs[2] = '{2'b01, 5'd0,  5'd8,  6'd45, 6'd46, 6'd12, 6'd8,  2'b00};
    vecs[3] = '{2'b10, 5'd11, 5'd0,  6'd44, 6'd46, 6'd11, 6'd13, 2'b00};
    vecs[4] = '{2'b00, 5'd10, 5'd10, 6'd47, 6'd47, 6'd10, 6'd10, 2'b00};
    vecs[5] = '{2'b11, 5'd0,  5'd12, 6'd48, 6'd49, 6'd1,  6'd12, 2'b10};

    // Reset, then walk the identity map.
    tick(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
    tick(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
    do_flush();
    idle(WALK + 1);

    // Table vectors, then a walk to confirm the committed map.
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].p0, vecs[i].p1,
           vecs[i].o0, vecs[i].o1, vecs[i].exp_rv);
    end
    idle(1);
    do_flush();
    idle(WALK + 1);

    // Commit alongside flush, then commits held valid through the walk.
    tick(1'b0, 1'b1, 2'b01, 5'd3, 5'd0, 6'd50, 6'd0, 6'd3, 6'd0, 2'b01);
    repeat (WALK + 1) tick(1'b0, 1'b0, 2'b11, 5'd4, 5'd6, 6'd51, 6'd52, 6'd4, 6'd6, 2'b00);
    tick(1'b0, 1'b0, 2'b11, 5'd4, 5'd6, 6'd51, 6'd52, 6'd4, 6'd6, 2'b11);
    do_flush();
    idle(WALK + 1);

    // Random commits.
    for (int i = 0; i < 20; i++) begin
      rv   = 2'($urandom_range(0, 3));
      rd0  = AW'($urandom_range(0, AN - 1));
      rd1  = AW'($urandom_range(0, AN - 1));
      rp0  = PW'($urandom_range(AN, PN - 1));
      rp1  = PW'($urandom_range(AN, PN - 1));
      ro0  = PW'($urandom_range(0, PN - 1));
      ro1  = PW'($urandom_range(0, PN - 1));
      rexp = {rv[1] && (rd1 != 0), rv[0] && (rd0 != 0)};
      tick(1'b0, 1'b0, rv, rd0, rd1, rp0, rp1, ro0, ro1, rexp);
    end
    do_flush();
    idle(WALK + 1);

    // Reset during walk cycle 8, then a walk with a second flush ignored.
    do_flush();
    idle(7);
    tick(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
    idle(1);
    do_flush();
    idle(3);
    do_flush();
    idle(WALK - 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
